ahb3lite_sram_ws: RTL and testbench

// AHB3-Lite slave wrapping an on-chip synchronous SRAM (existing mem sub-module).

---
 rtl/ahb3lite_pkg.sv | 42 ++++
 rtl/ahb3lite_sram_ws_mem.sv | 43 ++++
 rtl/ahb3lite_sram_ws.sv | 181 ++++++++++++++++++
 tb/tb_ahb3lite_sram_ws.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings, slave FSM state type and the byte-enable helper
// used by the wait-state SRAM slave.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_B8    = 3'b000;
  localparam logic [2:0] HSIZE_B16   = 3'b001;
  localparam logic [2:0] HSIZE_B32   = 3'b010;
  localparam logic [2:0] HSIZE_B64   = 3'b011;
  localparam logic [2:0] HSIZE_B128  = 3'b100;
  localparam logic [2:0] HSIZE_B256  = 3'b101;
  localparam logic [2:0] HSIZE_B512  = 3'b110;
  localparam logic [2:0] HSIZE_B1024 = 3'b111;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Widest supported data bus is 1024 bits, i.e. 128 byte lanes.
  localparam int MAX_BE = 128;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} ahb_slv_state_t;

  // Byte lanes touched by a transfer of 2**hsize bytes at addr_lo within a
  // be_size-byte word; callers truncate the result to their own lane count.
  function automatic logic [MAX_BE-1:0] gen_be(input logic [2:0] hsize,
                                               input logic [6:0] addr_lo,
                                               input int         be_size);
    int off;
    int nbytes;
    gen_be = '0;
    nbytes = 1 << hsize;
    off    = int'(addr_lo) & (be_size - 1);
    for (int i = 0; i < MAX_BE; i++) begin
      gen_be[i] = (i < be_size) && (i >= off) && (i < off + nbytes);
    end
  endfunction

endpackage

// File: rtl/ahb3lite_sram_ws_mem.sv
// Simple dual-port synchronous SRAM: one byte-masked write port, one registered
// read port (read-before-write when both hit the same word on one edge).
module ahb3lite_sram_ws_mem #(
  parameter int ABITS = 8,
  parameter int DBITS = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [ABITS-1:0]   waddr,
  input  logic [DBITS/8-1:0] wbe,
  input  logic [DBITS-1:0]   wdata,
  input  logic               re,
  input  logic [ABITS-1:0]   raddr,
  output logic [DBITS-1:0]   rdata
);

  logic [DBITS-1:0] mem_q [2**ABITS];
  logic [DBITS-1:0] rdata_q, rdata_d;

  // NOTE: the array is deliberately left out of reset so contents survive
  // HRESETn and the storage can map onto an SRAM macro.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DBITS/8; i++) begin
        if (wbe[i]) mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ahb3lite_sram_ws.sv
// AHB3-Lite SRAM slave with programmable read/write wait states, two-cycle
// ERROR response and same-word write-to-read forwarding.
module ahb3lite_sram_ws
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE = 16,
  parameter int HDATA_SIZE = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int RD_WAIT    = 0,
  parameter int WR_WAIT    = 0,
  parameter int PRIV_WR    = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int         BE_SIZE   = HDATA_SIZE / 8;
  localparam int         BOFF      = $clog2(BE_SIZE);
  localparam int         ABITS     = $clog2(MEM_DEPTH);
  localparam int         MEM_BYTES = MEM_DEPTH * BE_SIZE;
  localparam logic [3:0] RD_WS     = 4'(RD_WAIT);
  localparam logic [3:0] WR_WS     = 4'(WR_WAIT);

  ahb_slv_state_t        state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  hreadyout_q, hreadyout_d;
  logic                  hresp_q, hresp_d;
  logic                  dp_wr_q, dp_wr_d;
  logic [ABITS-1:0]      dp_addr_q, dp_addr_d;
  logic [BE_SIZE-1:0]    dp_be_q, dp_be_d;
  logic [BE_SIZE-1:0]    fwd_be_q, fwd_be_d;
  logic [HDATA_SIZE-1:0] fwd_data_q, fwd_data_d;

  logic                  accept, addr_err, wr_commit, rd_issue;
  logic [6:0]            align_mask;
  logic [3:0]            ws;
  logic [ABITS-1:0]      haddr_word;
  logic [BE_SIZE-1:0]    haddr_be;
  logic [HDATA_SIZE-1:0] mem_rdata;
  logic                  unused_ok;

  // Accepting only while our own data phase is done keeps a stray HREADY from
  // overlapping two transfers.
  assign accept     = HSEL & HREADY & HTRANS[1] & hreadyout_q;
  assign haddr_word = HADDR[ABITS+BOFF-1:BOFF];
  assign haddr_be   = BE_SIZE'(gen_be(HSIZE, HADDR[6:0], BE_SIZE));
  assign ws         = HWRITE ? WR_WS : RD_WS;
  assign wr_commit  = dp_wr_q & hreadyout_q;
  assign rd_issue   = accept & ~HWRITE & ~addr_err;
  assign unused_ok  = ^{HBURST, HPROT[3:2], HPROT[0]};

  always_comb begin
    align_mask = ~(7'h7f << HSIZE);
    addr_err   = (32'(HADDR) >= MEM_BYTES)
              || (int'(HSIZE) > BOFF)
              || (|(HADDR[6:0] & align_mask))
              || ((PRIV_WR != 0) && HWRITE && !HPROT[1]);
  end

  // NOTE: every _d starts from its _q so no path through this block leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    dp_wr_d     = dp_wr_q;
    dp_addr_d   = dp_addr_q;
    dp_be_d     = dp_be_q;
    fwd_be_d    = fwd_be_q;
    fwd_data_d  = fwd_data_q;

    unique case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) begin
          state_d     = ST_IDLE;
          hreadyout_d = 1'b1;
        end
      end
      ST_ERR1: begin
        state_d     = ST_ERR2;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_ERROR;
      end
      default: begin
        // ST_IDLE / ST_ERR2: any open data phase completes on this edge.
        state_d     = ST_IDLE;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
        dp_wr_d     = 1'b0;
        if (accept) begin
          dp_addr_d = haddr_word;
          dp_be_d   = haddr_be;
          if (addr_err) begin
            state_d     = ST_ERR1;
            hreadyout_d = 1'b0;
            hresp_d     = HRESP_ERROR;
          end else begin
            dp_wr_d = HWRITE;
            if (ws != 4'd0) begin
              state_d     = ST_WAIT;
              cnt_d       = ws;
              hreadyout_d = 1'b0;
            end
          end
        end
      end
    endcase

    // The SRAM returns pre-write data when a write commits on the read's edge.
    if (rd_issue) begin
      fwd_be_d   = (wr_commit && dp_addr_q == haddr_word) ? dp_be_q : '0;
      fwd_data_d = HWDATA;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      dp_wr_q     <= 1'b0;
      dp_addr_q   <= '0;
      dp_be_q     <= '0;
      fwd_be_q    <= '0;
      fwd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      dp_wr_q     <= dp_wr_d;
      dp_addr_q   <= dp_addr_d;
      dp_be_q     <= dp_be_d;
      fwd_be_q    <= fwd_be_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  ahb3lite_sram_ws_mem #(
    .ABITS(ABITS),
    .DBITS(HDATA_SIZE)
  ) u_mem (
    .clk  (HCLK),
    .rst_n(HRESETn),
    .we   (wr_commit),
    .waddr(dp_addr_q),
    .wbe  (dp_be_q),
    .wdata(HWDATA),
    .re   (rd_issue),
    .raddr(haddr_word),
    .rdata(mem_rdata)
  );

  always_comb begin
    HRDATA = mem_rdata;
    for (int i = 0; i < BE_SIZE; i++) begin
      if (fwd_be_q[i]) HRDATA[8*i +: 8] = fwd_data_q[8*i +: 8];
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb3lite_sram_ws.sv
// Self-checking bench: directed vector table, randomized traffic scored against
// a byte-array memory model, and hand-written reset/idle sequences.
module tb_ahb3lite_sram_ws;

  localparam int         RD_WAIT = 2;
  localparam int         WR_WAIT = 1;
  localparam logic [3:0] PRIV    = 4'b0011;
  localparam logic [3:0] USR     = 4'b0001;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [15:0] HADDR;
  logic [31:0] HWDATA, HRDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;

  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  ahb3lite_sram_ws #(
    .HADDR_SIZE(16), .HDATA_SIZE(32), .MEM_DEPTH(256),
    .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .PRIV_WR(1)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic [31:0] wdata;
    logic        exp_resp;
    int          exp_waits;
    logic [31:0] exp_rdata;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] ref_mem [1024];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t vec(input logic wr, input logic [15:0] addr, input logic [2:0] size,
                               input logic [3:0] prot, input logic [31:0] wdata,
                               input logic exp_resp, input int exp_waits, input logic [31:0] exp_rdata);
    vec_t v;
    v.wr = wr; v.addr = addr; v.size = size; v.prot = prot; v.wdata = wdata;
    v.exp_resp = exp_resp; v.exp_waits = exp_waits; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  // Sequential memory semantics: each transfer sees every earlier write.
  function automatic vec_t model(input logic wr, input logic [15:0] addr, input logic [2:0] size,
                                 input logic [3:0] prot, input logic [31:0] wdata);
    int   a, nb;
    bit   err;
    vec_t v;
    a  = int'(addr);
    nb = 1 << size;
    err = (a >= 1024) || (nb > 4) || (a % nb != 0) || (wr && !prot[1]);
    v = vec(wr, addr, size, prot, wdata, err, err ? 1 : (wr ? WR_WAIT : RD_WAIT), 32'h0);
    if (!err && wr)
      for (int b = 0; b < nb; b++) ref_mem[a + b] = wdata[8*((a + b) % 4) +: 8];
    if (!err && !wr)
      for (int b = 0; b < 4; b++) v.exp_rdata[8*b +: 8] = ref_mem[(a & ~3) + b];
    return v;
  endfunction

  task automatic drive_addr(input vec_t v[$], input int i);
    HBURST = 3'b000;
    if (i < v.size()) begin
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = v[i].addr; HWRITE = v[i].wr;
      HSIZE = v[i].size; HPROT = v[i].prot;
    end else begin
      HSEL = 1'b1; HTRANS = 2'b00;
    end
  endtask

  // Pipelined master: next address phase is presented during the current data phase.
  task automatic run(input vec_t v[$]);
    int   i, guard, limit, waits, dpi;
    bit   dp, rdy, wresp_bad;
    vec_t d;
    i = 0; guard = 0; waits = 0; dpi = 0; dp = 0; wresp_bad = 0;
    limit = 50 * v.size() + 20;
    d = vec(1'b0, 16'h0, 3'd0, 4'h0, 32'h0, 1'b0, 0, 32'h0);
    drive_addr(v, 0);
    while ((i < v.size() || dp) && guard < limit) begin
      @(negedge HCLK);
      guard++;
      rdy = HREADYOUT;
      if (dp) begin
        if (!rdy) begin
          waits++;
          if (HRESP !== d.exp_resp) wresp_bad = 1'b1;
        end else begin
          check($sformatf("waits[%0d]", dpi), 32'(waits), 32'(d.exp_waits));
          check($sformatf("resp[%0d]", dpi), {30'b0, wresp_bad, HRESP}, {31'b0, d.exp_resp});
          if (!d.wr && !d.exp_resp)
            check($sformatf("rdata[%0d]@%04h", dpi, d.addr), HRDATA, d.exp_rdata);
        end
      end
      @(posedge HCLK);
      #1;
      if (rdy) begin
        dp = (i < v.size());
        if (dp) begin
          d = v[i]; dpi = i; HWDATA = d.wdata; waits = 0; wresp_bad = 1'b0; i++;
        end
        drive_addr(v, i);
      end
    end
    if (i < v.size() || dp) begin
      vectors++; miscompares++;
      $display("FAIL run_timeout: got %0d of %0d transfers issued, transfer pending=%0d", i, v.size(), dp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (!HREADYOUT && n < 40);
    if (!HREADYOUT) check("ready_timeout", {31'b0, HREADYOUT}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag, input bit with_rdata);
    check({tag, "_ready"}, {31'b0, HREADYOUT}, 32'd1);
    check({tag, "_resp"},  {31'b0, HRESP},     32'd0);
    if (with_rdata) check({tag, "_rdata"}, HRDATA, 32'h0);
  endtask

  task automatic idle_tests();
    vec_t q[$];
    HSEL = 1'b0; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 16'h0010;
    HSIZE = 3'd2; HPROT = PRIV; HWDATA = 32'h0;
    @(negedge HCLK); check_idle_outputs("nosel", 1'b0);
    @(posedge HCLK); #1; HSEL = 1'b1; HTRANS = 2'b01;
    @(negedge HCLK); check_idle_outputs("busy", 1'b0);
    @(posedge HCLK); #1; HTRANS = 2'b00;
    @(negedge HCLK); check_idle_outputs("idle", 1'b0);
    @(posedge HCLK); #1;
    q.push_back(vec(1'b0, 16'h0010, 3'd2, PRIV, 32'h0, 1'b0, RD_WAIT, 32'hAAADBEEF));
    run(q);
  endtask

  task automatic random_test();
    vec_t        q[$];
    logic        wr;
    int          sz, a;
    logic [3:0]  prot;
    for (int w = 0; w < 256; w++) q.push_back(model(1'b1, 16'(4 * w), 3'd2, PRIV, $urandom()));
    run(q);
    q.delete();
    for (int n = 0; n < 300; n++) begin
      wr   = 1'($urandom_range(0, 1));
      sz   = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : 3;
      a    = ($urandom_range(0, 9) == 0) ? $urandom_range(1024, 1279)
           : ($urandom_range(0, 1) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 1023);
      if ($urandom_range(0, 7) != 0) a = a & ~((1 << sz) - 1);
      prot = ($urandom_range(0, 7) == 0) ? USR : PRIV;
      q.push_back(model(wr, 16'(a), 3'(sz), prot, $urandom()));
    end
    run(q);
  endtask

  task automatic burst_reset_test();
    logic [31:0] bd [4];
    vec_t        q[$];
    bd[0] = 32'hC0DE0001; bd[1] = 32'hC0DE0002; bd[2] = 32'hC0DE0003; bd[3] = 32'hC0DE0004;
    HSEL = 1'b1; HTRANS = 2'b10; HBURST = 3'b011; HWRITE = 1'b1;
    HSIZE = 3'd2; HPROT = PRIV; HADDR = 16'h0040;
    for (int b = 0; b < 3; b++) begin
      wait_ready();
      @(posedge HCLK); #1;
      HWDATA = bd[b]; HTRANS = 2'b11; HADDR = 16'h0040 + 16'(4 * (b + 1));
    end
    @(negedge HCLK);
    check("burst_beat3_wait", {31'b0, HREADYOUT}, 32'd0);
    HRESETn = 1'b0;
    #1;
    check_idle_outputs("async_rst", 1'b1);
    HTRANS = 2'b00; HSEL = 1'b0;
    @(negedge HCLK); check_idle_outputs("in_rst", 1'b1);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    q.push_back(model(1'b0, 16'h0040, 3'd2, PRIV, 32'h0));
    q.push_back(model(1'b0, 16'h0044, 3'd2, PRIV, 32'h0));
    q.push_back(model(1'b0, 16'h0048, 3'd2, PRIV, 32'h0));
    q.push_back(model(1'b0, 16'h004C, 3'd2, PRIV, 32'h0));
    q[0].exp_rdata = bd[0];
    q[1].exp_rdata = bd[1];
    run(q);
  endtask

  initial begin
    vec_t dir_q[$];

    dir_q.push_back(vec(1'b1, 16'h0010, 3'd2, PRIV, 32'hDEADBEEF, 1'b0, WR_WAIT, 32'h0));
    dir_q.push_back(vec(1'b0, 16'h0010, 3'd2, PRIV, 32'h0,        1'b0, RD_WAIT, 32'hDEADBEEF));
    dir_q.push_back(vec(1'b1, 16'h0013, 3'd0, PRIV, 32'hAAAAAAAA, 1'b0, WR_WAIT, 32'h0));
    dir_q.push_back(vec(1'b0, 16'h0010, 3'd2, PRIV, 32'h0,        1'b0, RD_WAIT, 32'hAAADBEEF));
    dir_q.push_back(vec(1'b0, 16'h0400, 3'd2, PRIV, 32'h0,        1'b1, 1,       32'h0));
    dir_q.push_back(vec(1'b0, 16'h0010, 3'd2, USR,  32'h0,        1'b0, RD_WAIT, 32'hAAADBEEF));
    dir_q.push_back(vec(1'b1, 16'h0011, 3'd1, PRIV, 32'h12345678, 1'b1, 1,       32'h0));
    dir_q.push_back(vec(1'b1, 16'h0010, 3'd2, USR,  32'h11111111, 1'b1, 1,       32'h0));
    dir_q.push_back(vec(1'b1, 16'h0010, 3'd3, PRIV, 32'h22222222, 1'b1, 1,       32'h0));
    dir_q.push_back(vec(1'b0, 16'h0010, 3'd2, PRIV, 32'h0,        1'b0, RD_WAIT, 32'hAAADBEEF));
    dir_q.push_back(vec(1'b1, 16'h03FC, 3'd2, PRIV, 32'h0BADF00D, 1'b0, WR_WAIT, 32'h0));
    dir_q.push_back(vec(1'b1, 16'h03FE, 3'd1, PRIV, 32'h55660000, 1'b0, WR_WAIT, 32'h0));
    dir_q.push_back(vec(1'b0, 16'h03FF, 3'd0, PRIV, 32'h0,        1'b0, RD_WAIT, 32'h5566F00D));
    dir_q.push_back(vec(1'b0, 16'h03FC, 3'd2, PRIV, 32'h0,        1'b0, RD_WAIT, 32'h5566F00D));
    dir_q.push_back(vec(1'b1, 16'h0400, 3'd0, PRIV, 32'h0,        1'b1, 1,       32'h0));

    HSEL = 1'b0; HWRITE = 1'b0; HADDR = '0; HWDATA = '0; HSIZE = 3'd2;
    HBURST = 3'b000; HPROT = PRIV; HTRANS = 2'b00;

    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check_idle_outputs("reset", 1'b1);
    HRESETn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge HCLK);
      check_idle_outputs("post_reset", 1'b1);
    end

    @(posedge HCLK); #1;
    run(dir_q);
    @(negedge HCLK);
    check_idle_outputs("err_cancel", 1'b0);
    @(posedge HCLK); #1;
    idle_tests();
    random_test();
    burst_reset_test();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
